// File: rtl/booth_mult8_sequencer_if.sv
// Request/result handshake bundle between a client and booth_mult8_sequencer.
// The client holds the master modport; the sequencer holds the slave modport.
interface booth_mult8_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [1:0]           in_sign_mode;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic [TAG_W-1:0]     out_tag;

    modport master (
        output in_valid, in_a, in_b, in_sign_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_product, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sign_mode, in_tag, out_ready,
        output in_ready, out_valid, out_product, out_tag
    );
endinterface

// File: rtl/booth_mult8_sequencer.sv
// Issue stage for booth_mult8_core: launches one multiply at a time, collects the
// tagged product into a small result FIFO and abandons ops whose core never answers.
module booth_mult8_sequencer #(
    parameter int WIDTH     = 8,
    parameter int TAG_W     = 4,
    parameter int RES_DEPTH = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    booth_mult8_sequencer_if.slave bus,
    output logic                  core_start,
    output logic [WIDTH-1:0]      core_multiplicand,
    output logic [WIDTH-1:0]      core_multiplier,
    output logic [1:0]            core_sign_mode,
    input  logic [2*WIDTH-1:0]    core_product,
    input  logic                  core_done,
    output logic                  busy,
    output logic                  err,
    input  logic                  err_clr
);
    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t              state;
    logic [TAG_W-1:0]    tag_q;
    logic [TO_W-1:0]     wait_cnt;

    logic [2*WIDTH-1:0]  prod_mem [RES_DEPTH];
    logic [TAG_W-1:0]    tag_mem  [RES_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;

    logic                accept;
    logic                push;
    logic                pop;

    // Only one op is ever outstanding, so a free FIFO slot at accept time
    // guarantees room for its result.
    assign bus.in_ready  = (state == S_IDLE) && (fifo_count < CNT_W'(RES_DEPTH)) && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = (state == S_WAIT) && core_done;
    assign bus.out_valid = (fifo_count != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_product = prod_mem[rd_ptr];
    assign bus.out_tag     = tag_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            core_start        <= 1'b0;
            core_multiplicand <= '0;
            core_multiplier   <= '0;
            core_sign_mode    <= '0;
            tag_q             <= '0;
            wait_cnt          <= '0;
            busy              <= 1'b0;
            err               <= 1'b0;
        end else begin
            if (err_clr)
                err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        core_multiplicand <= bus.in_a;
                        core_multiplier   <= bus.in_b;
                        core_sign_mode    <= bus.in_sign_mode;
                        tag_q             <= bus.in_tag;
                        core_start        <= 1'b1;
                        wait_cnt          <= '0;
                        busy              <= 1'b1;
                        state             <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    core_start <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion on the last allowed cycle still counts as success.
                    if (core_done) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                default: begin
                    core_start <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            prod_mem[wr_ptr] <= core_product;
            tag_mem[wr_ptr]  <= tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult8_sequencer.sv
// Bench for booth_mult8_sequencer: a latency-programmable core model plus a
// queue-based scoreboard of expected {product, tag} results.
module tb_booth_mult8_sequencer;
    localparam int WIDTH     = 8;
    localparam int TAG_W     = 4;
    localparam int RES_DEPTH = 2;
    localparam int TIMEOUT   = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_start;
    logic [7:0]  core_multiplicand;
    logic [7:0]  core_multiplier;
    logic [1:0]  core_sign_mode;
    logic [15:0] core_product;
    logic        core_done;
    logic        busy;
    logic        err;
    logic        err_clr;

    always #5 clk = ~clk;

    booth_mult8_sequencer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    booth_mult8_sequencer #(
        .WIDTH(WIDTH), .TAG_W(TAG_W), .RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .core_start(core_start),
        .core_multiplicand(core_multiplicand),
        .core_multiplier(core_multiplier),
        .core_sign_mode(core_sign_mode),
        .core_product(core_product),
        .core_done(core_done),
        .busy(busy),
        .err(err),
        .err_clr(err_clr)
    );

    typedef struct packed {
        logic [15:0] prod;
        logic [3:0]  tag;
    } res_t;

    res_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   core_lat  = 4;
    bit   core_dead = 1'b0;
    bit   accepted  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        end
    endtask

    function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b,
                                               input logic [1:0] mode);
        int av;
        int bv;
        int p;
        av = mode[1] ? int'($signed(a)) : int'(a);
        bv = mode[0] ? int'($signed(b)) : int'(b);
        p  = av * bv;
        return p[15:0];
    endfunction

    // Core model: done pulses core_lat cycles after the start cycle's successor.
    initial begin
        int          cd;
        bit          pend;
        logic [15:0] p;
        cd = 0;
        pend = 1'b0;
        p = '0;
        core_done = 1'b0;
        core_product = '0;
        forever begin
            @(posedge clk);
            #2;
            core_done = 1'b0;
            if (pend) begin
                if (cd == 0) begin
                    core_done    = 1'b1;
                    core_product = p;
                    pend         = 1'b0;
                end else begin
                    cd--;
                end
            end
            if (core_start && !core_dead) begin
                pend = 1'b1;
                cd   = core_lat;
                p    = refProduct(core_multiplicand, core_multiplier, core_sign_mode);
            end
        end
    end

    task automatic applyStimulus(input bit valid, input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] mode, input logic [3:0] tag);
        bus.in_valid     = valid;
        bus.in_a         = a;
        bus.in_b         = b;
        bus.in_sign_mode = mode;
        bus.in_tag       = tag;
    endtask

    // Scoreboard bookkeeping for the coming edge, then advance to the next negedge.
    task automatic clockCycle();
        res_t r;
        accepted = 1'b0;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    checkOutput("head_product", 32'(bus.out_product), 32'(exp_q[0].prod));
                    checkOutput("head_tag", 32'(bus.out_tag), 32'(exp_q[0].tag));
                    if (bus.out_ready)
                        void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                accepted = 1'b1;
                if (!core_dead) begin
                    r.prod = refProduct(bus.in_a, bus.in_b, bus.in_sign_mode);
                    r.tag  = bus.in_tag;
                    exp_q.push_back(r);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sendOp(input logic [7:0] a, input logic [7:0] b, input logic [1:0] mode,
                          input logic [3:0] tag);
        bit ok;
        ok = 1'b0;
        applyStimulus(1'b1, a, b, mode, tag);
        for (int i = 0; i < 100; i++) begin
            clockCycle();
            if (accepted) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        checkOutput("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !busy && !bus.out_valid)
                break;
            clockCycle();
        end
        checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic waitResult(input string name, input logic [15:0] prod, input logic [3:0] tag);
        bit seen;
        seen = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            clockCycle();
        end
        checkOutput({name, "_seen"}, 32'(seen), 32'd1);
        checkOutput({name, "_product"}, 32'(bus.out_product), 32'(prod));
        checkOutput({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
        drain();
    endtask

    initial begin
        int  c;
        bit  any_acc;
        int  ops_left;
        bus.out_ready = 1'b0;
        err_clr = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 4'h0);

        // Reset state
        rst = 1'b1;
        @(negedge clk);
        clockCycle();
        clockCycle();
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_core_start", 32'(core_start), 32'd0);
        checkOutput("rst_operands", {14'd0, core_multiplicand, core_multiplier, core_sign_mode}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Test 1: latency and signed product
        core_lat = 4;
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 8'hFD, 8'h05, 2'b11, 4'd1);
        clockCycle();
        checkOutput("t1_accept", 32'(accepted), 32'd1);
        bus.in_valid = 1'b0;
        checkOutput("t1_start_c1", 32'(core_start), 32'd1);
        checkOutput("t1_busy_c1", 32'(busy), 32'd1);
        for (c = 2; c <= 7; c++) begin
            clockCycle();
            checkOutput($sformatf("t1_start_c%0d", c), 32'(core_start), 32'd0);
            checkOutput($sformatf("t1_out_valid_c%0d", c), 32'(bus.out_valid), 32'(c == 7));
            checkOutput($sformatf("t1_in_ready_c%0d", c), 32'(bus.in_ready), 32'(c == 7));
            checkOutput($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(c < 7));
            if (c < 7)
                checkOutput($sformatf("t1_opa_c%0d", c), 32'(core_multiplicand), 32'hFD);
        end
        checkOutput("t1_product", 32'(bus.out_product), 32'hFFF1);
        checkOutput("t1_tag", 32'(bus.out_tag), 32'd1);
        drain();

        // Test 2: unsigned and mixed sign
        sendOp(8'hFF, 8'hFF, 2'b00, 4'd2);
        waitResult("t2_uu", 16'hFE01, 4'd2);
        sendOp(8'hFF, 8'hFF, 2'b10, 4'd2);
        waitResult("t2_su", 16'hFF01, 4'd2);

        // Test 3: FIFO full backpressure, order preserved
        bus.out_ready = 1'b0;
        sendOp(8'd3, 8'd7, 2'b00, 4'd3);
        sendOp(8'h80, 8'd2, 2'b10, 4'd4);
        applyStimulus(1'b1, 8'd9, 8'hF0, 2'b01, 4'd5);
        any_acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clockCycle();
            any_acc |= accepted;
        end
        checkOutput("t3_tag5_held", 32'(any_acc), 32'd0);
        checkOutput("t3_full_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("t3_full_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("t3_head_tag", 32'(bus.out_tag), 32'd3);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && !any_acc; i++) begin
            clockCycle();
            any_acc |= accepted;
        end
        bus.in_valid = 1'b0;
        checkOutput("t3_tag5_accepted", 32'(any_acc), 32'd1);
        drain();

        // Test 4: timeout, then set-wins-over-clear
        core_dead = 1'b1;
        sendOp(8'd1, 8'd1, 2'b00, 4'd8);
        c = 1;
        while (!err && c < 40) begin
            clockCycle();
            c++;
        end
        checkOutput("t4_timeout_cycle", 32'(c), 32'(TIMEOUT + 2));
        checkOutput("t4_busy", 32'(busy), 32'd0);
        checkOutput("t4_out_valid", 32'(bus.out_valid), 32'd0);
        err_clr = 1'b1;
        clockCycle();
        err_clr = 1'b0;
        checkOutput("t4_err_clr", 32'(err), 32'd0);
        err_clr = 1'b1;
        sendOp(8'd2, 8'd2, 2'b00, 4'd9);
        c = 1;
        while (!err && c < 40) begin
            clockCycle();
            c++;
        end
        checkOutput("t4_set_wins_cycle", 32'(c), 32'(TIMEOUT + 2));
        clockCycle();
        checkOutput("t4_err_cleared", 32'(err), 32'd0);
        err_clr = 1'b0;
        core_dead = 1'b0;

        // Test 5: reset mid-WAIT, stale done ignored
        core_lat = 4;
        sendOp(8'd5, 8'd6, 2'b00, 4'd10);
        clockCycle();
        clockCycle();
        checkOutput("t5_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t5_in_ready_rst", 32'(bus.in_ready), 32'd0);
        clockCycle();
        rst = 1'b0;
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_core_start", 32'(core_start), 32'd0);
        checkOutput("t5_operands", {14'd0, core_multiplicand, core_multiplier, core_sign_mode}, 32'd0);
        any_acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            clockCycle();
            any_acc |= bus.out_valid | busy | err;
        end
        checkOutput("t5_stale_ignored", 32'(any_acc), 32'd0);
        checkOutput("t5_in_ready", 32'(bus.in_ready), 32'd1);

        // Test 6: pop coinciding with push at count 1
        bus.out_ready = 1'b0;
        sendOp(8'd11, 8'd12, 2'b00, 4'd6);
        for (int i = 0; i < 30 && !bus.out_valid; i++)
            clockCycle();
        sendOp(8'hF5, 8'd13, 2'b10, 4'd7);
        any_acc = 1'b0;
        for (int i = 0; i < 30 && !any_acc; i++) begin
            bus.out_ready = core_done;
            any_acc = core_done;
            clockCycle();
        end
        bus.out_ready = 1'b0;
        checkOutput("t6_coincident", 32'(any_acc), 32'd1);
        checkOutput("t6_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("t6_head_tag", 32'(bus.out_tag), 32'd7);
        checkOutput("t6_head_product", 32'(bus.out_product), 32'(refProduct(8'hF5, 8'd13, 2'b10)));
        checkOutput("t6_in_ready", 32'(bus.in_ready), 32'd1);
        drain();

        // Randomized traffic with random backpressure and core latency
        ops_left = 25;
        for (int i = 0; i < 3000 && ops_left > 0; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (!bus.in_valid && $urandom_range(0, 2) != 0) begin
                core_lat = $urandom_range(0, 6);
                applyStimulus(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 4'($urandom));
            end
            clockCycle();
            if (accepted) begin
                bus.in_valid = 1'b0;
                ops_left--;
            end
        end
        bus.in_valid = 1'b0;
        checkOutput("rand_all_sent", 32'(ops_left), 32'd0);
        drain();
        checkOutput("final_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
